// File: rtl/dmem_lsu_master.sv
// dmem_lsu_master: load/store initiator between the MEM stage and a byte-addressed,
// word-wide data memory. Loads return byte/half/word with sign or zero extension.
// Byte and half stores become read-modify-write, because the memory only writes
// full words.
// Optional feature: define DMEM_LSU_ALIGN_CHECK_EN to reject misaligned half/word
// accesses and the reserved size 11. Rejected accesses are answered with rsp_err=1
// and never touch the memory. Without the macro, every alignment is accepted,
// size 11 behaves as a word, and rsp_err is tied to 0.
// Handshake: a request transfers on a posedge where req_valid && req_ready.
// req_ready is high only in IDLE. rsp_valid is a one-cycle pulse and cannot be
// backpressured.
module dmem_lsu_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  dm_we,
    output logic [ADDR_WIDTH-1:0] dm_addr,
    output logic [DATA_WIDTH-1:0] dm_wd,
    input  logic [DATA_WIDTH-1:0] dm_rd,
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [15:0]           wdata_q;
    logic [DATA_WIDTH-1:0] dm_wd_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] rmw_word;
    logic                  accept;
    logic                  req_bad;

    assign req_ready   = (state_q == S_IDLE) && !reset;
    assign accept      = req_valid && req_ready;
    assign dm_we       = (state_q == S_WRITE) && !reset;
    assign dm_addr     = addr_q;
    assign dm_wd       = dm_wd_q;
    assign rsp_valid   = (state_q == S_RESP) && !reset;
    assign rsp_rdata   = rdata_q;
    assign dbg_state_o = state_q;

`ifdef DMEM_LSU_ALIGN_CHECK_EN
    logic err_q;

    // Misaligned half/word and the reserved size are rejected at accept time.
    assign req_bad = ((req_size == 2'b01) && req_addr[0])
                  || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                  || (req_size == 2'b11);
    assign rsp_err = err_q;

    // Error flag changes only on entry to RESP and then holds until the next response.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept && req_bad) begin
            err_q <= 1'b1;
        end else if ((state_q == S_LOAD) || (state_q == S_WRITE)) begin
            err_q <= 1'b0;
        end
    end
`else
    assign req_bad = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Extend the low lane(s) of the read word; a word (or size 11) passes through.
    always_comb begin
        load_ext = dm_rd;
        case (size_q)
            2'b00:   load_ext = {{(DATA_WIDTH-8){!uns_q && dm_rd[7]}}, dm_rd[7:0]};
            2'b01:   load_ext = {{(DATA_WIDTH-16){!uns_q && dm_rd[15]}}, dm_rd[15:0]};
            default: load_ext = dm_rd;
        endcase
    end

    // Merge the store data into the low lane(s) of the word just read back.
    always_comb begin
        rmw_word = dm_rd;
        if (size_q == 2'b00) begin
            rmw_word = {dm_rd[DATA_WIDTH-1:8], wdata_q[7:0]};
        end else begin
            rmw_word = {dm_rd[DATA_WIDTH-1:16], wdata_q};
        end
    end

    // Next-state logic; the path is decided at accept time from the request fields.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_bad)                 state_d = S_RESP;
                    else if (!req_we)            state_d = S_LOAD;
                    else if (req_size[1] == 1'b0) state_d = S_RMW_RD;
                    else                         state_d = S_WRITE;
                end
            end
            S_LOAD:   state_d = S_RESP;
            S_RMW_RD: state_d = S_WRITE;
            S_WRITE:  state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register plus the captured request, memory write word and response data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            dm_wd_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata[15:0];
                if (req_bad) begin
                    rdata_q <= '0;
                end else if (req_we) begin
                    dm_wd_q <= req_wdata;
                end
            end
            case (state_q)
                S_LOAD:   rdata_q <= load_ext;
                S_RMW_RD: dm_wd_q <= rmw_word;
                S_WRITE:  rdata_q <= '0;
                default:  ;
            endcase
        end
    end

endmodule
